// File: rtl/pad_pkg.sv
// Shared types and default timing constants for the serial pad reader.
// Defaults target a 40 MHz clock polling NES/SNES pads at 60 Hz.
package pad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  localparam int DEF_HALF        = 240;
  localparam int DEF_POLL_CYCLES = 666_667;

endpackage

// File: rtl/pad_shift_reg.sv
// Per-pad sample-and-invert shifter, LSB-first.
// Bit k lands at index k after N_BITS samples.
module pad_shift_reg #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [N_BITS-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {~din, q[N_BITS-1:1]};
    end
  end

endmodule

// File: rtl/multi_pad_reader.sv
// Polls N_PADS serial pads over a shared latch/pulse pair.
// Produces held button state plus a one-cycle newly-pressed strobe.
module multi_pad_reader
  import pad_pkg::*;
#(
  parameter int N_PADS      = 2,
  parameter int N_BITS      = 8,
  parameter int HALF        = DEF_HALF,
  parameter int POLL_CYCLES = DEF_POLL_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     auto_mode,
  input  logic                     start,
  input  logic [N_PADS-1:0]        pad_data,
  output logic                     latch,
  output logic                     pulse,
  output logic                     busy,
  output logic [N_PADS*N_BITS-1:0] buttons,
  output logic [N_PADS*N_BITS-1:0] pressed,
  output logic                     valid
);

  localparam int CW = $clog2(2 * HALF);
  localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int PW = $clog2(POLL_CYCLES + 1);

  localparam logic [CW-1:0] LAST_HALF  = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST_LATCH = CW'(2 * HALF - 1);
  localparam logic [KW-1:0] LAST_BIT   = KW'(N_BITS - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

  state_t state;
  state_t state_n;

  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic [PW-1:0] poll_cnt;
  logic          kick;
  logic          sample;
  logic          entering;

  logic [N_PADS*N_BITS-1:0] shift_all;

  assign entering = (state_n == S_LATCH) && (state != S_LATCH);

  always_comb begin
    state_n = state;
    sample  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (auto_mode ? (kick || poll_cnt >= POLL_LAST) : start)
          state_n = S_LATCH;
      end
      S_LATCH: begin
        if (cnt == LAST_LATCH)
          state_n = S_LOW;
      end
      S_LOW: begin
        if (cnt == LAST_HALF) begin
          sample  = 1'b1;
          state_n = (k == LAST_BIT) ? S_DONE : S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt == LAST_HALF)
          state_n = S_LOW;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      k        <= '0;
      poll_cnt <= '0;
      kick     <= 1'b1;
      latch    <= 1'b0;
      pulse    <= 1'b0;
      busy     <= 1'b0;
      buttons  <= '0;
      pressed  <= '0;
      valid    <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state || state == S_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == S_IDLE)
        k <= '0;
      else if (state == S_HIGH && state_n == S_LOW)
        k <= k + 1'b1;
      // Poll period is measured from LATCH entry; saturate so late polls go at once
      if (entering) begin
        poll_cnt <= '0;
        kick     <= 1'b0;
      end else if (poll_cnt != POLL_LAST) begin
        poll_cnt <= poll_cnt + 1'b1;
      end
      latch <= (state_n == S_LATCH);
      pulse <= (state_n == S_HIGH);
      busy  <= (state_n != S_IDLE);
      valid <= (state == S_DONE);
      if (state == S_DONE) begin
        buttons <= shift_all;
        pressed <= shift_all & ~buttons;
      end else begin
        pressed <= '0;
      end
    end
  end

  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    pad_shift_reg #(
      .N_BITS(N_BITS)
    ) u_shift (
      .clk  (clk),
      .reset(reset),
      .clr  (entering),
      .en   (sample),
      .din  (pad_data[p]),
      .q    (shift_all[p*N_BITS +: N_BITS])
    );
  end

endmodule

// File: tb/tb_multi_pad_reader.sv
// Directed bench for multi_pad_reader with a behavioural two-pad model.
// Small timing parameters keep each poll at 69 cycles.
module tb_multi_pad_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        auto_mode;
  logic        start;
  logic [1:0]  pad_data;
  logic        latch;
  logic        pulse;
  logic        busy;
  logic [15:0] buttons;
  logic [15:0] pressed;
  logic        valid;

  logic [7:0]  pat0;
  logic [7:0]  pat1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_pad_reader #(
    .N_PADS     (2),
    .N_BITS     (8),
    .HALF       (4),
    .POLL_CYCLES(200)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .auto_mode(auto_mode),
    .start    (start),
    .pad_data (pad_data),
    .latch    (latch),
    .pulse    (pulse),
    .busy     (busy),
    .buttons  (buttons),
    .pressed  (pressed),
    .valid    (valid)
  );

  // Pad model: latch reloads bit 0, each pulse rise advances one bit
  int   idx = 0;
  logic pulse_d = 1'b0;
  always @(negedge clk) begin
    if (latch) idx = 0;
    else if (pulse && !pulse_d) idx++;
    pulse_d = pulse;
  end
  assign pad_data = (idx < 8) ? {~pat1[idx[2:0]], ~pat0[idx[2:0]]} : 2'b11;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int latch_hi, pulse_hi, rises, n_valid, valid_at;
  int both, n_entry, bad_gap, first_entry;
  logic [15:0] v_btn, v_prs;

  task automatic watch(input int ncyc);
    logic pp, pl;
    int last;
    latch_hi = 0; pulse_hi = 0; rises = 0; n_valid = 0;
    valid_at = -1; both = 0; n_entry = 0; bad_gap = 0;
    first_entry = -1; last = -1; pp = 1'b0; pl = 1'b0;
    v_btn = '0; v_prs = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (latch) latch_hi++;
      if (pulse) pulse_hi++;
      if (pulse && !pp) rises++;
      if (latch && pulse) both++;
      if (latch && !pl) begin
        if (first_entry < 0) first_entry = i;
        if (last >= 0 && i - last != 200) bad_gap++;
        last = i;
        n_entry++;
      end
      if (valid) begin
        n_valid++;
        if (valid_at < 0) valid_at = i;
        v_btn = buttons;
        v_prs = pressed;
      end
      pp = pulse;
      pl = latch;
      @(negedge clk);
    end
  endtask

  task automatic kick_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; auto_mode = 1'b0; start = 1'b0;
    pat0 = 8'h00; pat1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_latch", latch, 0);
    check("rst_pulse", pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_buttons", buttons, 0);
    check("rst_valid", valid, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Manual poll, pad0 A + Start
    pat0 = 8'h09;
    kick_start();
    check("m_busy", busy, 1);
    watch(80);
    check("m_latch_len", latch_hi, 8);
    check("m_high_cnt", rises, 7);
    check("m_pulse_len", pulse_hi, 28);
    check("m_valid_at", valid_at, 69);
    check("m_valid_cnt", n_valid, 1);
    check("m_buttons", v_btn, 16'h0009);
    check("m_pressed", v_prs, 16'h0009);
    check("m_overlap", both, 0);
    check("m_busy_end", busy, 0);
    check("m_hold", buttons, 16'h0009);
    check("m_prs_clr", pressed, 0);

    // Same pattern again: held, not newly pressed
    kick_start();
    watch(80);
    check("h_valid_cnt", n_valid, 1);
    check("h_buttons", v_btn, 16'h0009);
    check("h_pressed", v_prs, 16'h0000);

    // Pad independence
    pat0 = 8'h00; pat1 = 8'h80;
    kick_start();
    watch(80);
    check("i_buttons", v_btn, 16'h8000);
    check("i_pressed", v_prs, 16'h8000);

    // Second start while busy is ignored
    kick_start();
    repeat (10) @(negedge clk);
    kick_start();
    watch(140);
    check("b_valid_cnt", n_valid, 1);
    check("b_entries", n_entry, 0);
    check("b_busy_end", busy, 0);
    check("b_buttons", v_btn, 16'h8000);
    check("b_pressed", v_prs, 16'h0000);

    // Reset during HIGH of bit 4
    pat0 = 8'h09; pat1 = 8'h00;
    kick_start();
    repeat (45) @(negedge clk);
    check("r_in_high", pulse, 1);
    reset = 1'b0;
    @(negedge clk);
    check("r_latch", latch, 0);
    check("r_pulse", pulse, 0);
    check("r_busy", busy, 0);
    check("r_buttons", buttons, 0);
    check("r_valid", valid, 0);
    reset = 1'b1;
    watch(80);
    check("r_no_valid", n_valid, 0);
    check("r_no_entry", n_entry, 0);

    // Auto mode from reset release
    reset = 1'b0; auto_mode = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    watch(1000);
    check("a_first", first_entry, 0);
    check("a_entries", n_entry, 5);
    check("a_gaps", bad_gap, 0);
    check("a_valids", n_valid, 5);
    check("a_buttons", v_btn, 16'h0009);
    check("a_overlap", both, 0);
    auto_mode = 1'b0;
    repeat (100) @(negedge clk);
    check("a_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_pad_reader.md
MULTI_PAD_READER -- requirements
Module: multi_pad_reader

Interface
REQ-001 SHALL have parameters: N_PADS, default 2, number of serial pads sharing latch/pulse (1..4).
REQ-002 SHALL have parameters: N_BITS, default 8, buttons per pad (8 = NES, 16 = SNES).
REQ-003 SHALL have parameters: HALF, default 240, clk cycles per half bit period (6 us at 40 MHz; min 2).
REQ-004 SHALL have parameters: POLL_CYCLES, default 666_667, auto-poll period in clk cycles (60 Hz).
REQ-005 SHALL have ports: clk  input  1  system clock, 40 MHz; single clock domain.
REQ-006 SHALL have ports: reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-007 SHALL have ports: auto_mode  input  1  1 = free-running polls every POLL_CYCLES; 0 = poll on start.
REQ-008 SHALL have ports: start  input  1  one-cycle poll request, honoured only when auto_mode = 0 and busy = 0.
REQ-009 SHALL have ports: pad_data  input  N_PADS  serial data per pad, active-low (0 = pressed), pre-synchronised.
REQ-010 SHALL have ports: latch  output  1  shared pad latch, active-high.
REQ-011 SHALL have ports: pulse  output  1  shared pad shift clock, active-high.
REQ-012 SHALL have ports: busy  output  1  high from poll start through DONE.
REQ-013 SHALL have ports: buttons  output  N_PADS*N_BITS  held state, active-high; pad p bit k at index p*N_BITS+k.
REQ-014 SHALL have ports: pressed  output  N_PADS*N_BITS  one-cycle strobe, 0->1 transitions since the last poll.
REQ-015 SHALL have ports: valid  output  1  one-cycle strobe that buttons/pressed were updated.

Function
REQ-016 SHALL implement FSM IDLE -> LATCH -> LOW -> HIGH -> LOW ... -> DONE -> IDLE, with bit index k = 0..N_BITS-1.
REQ-017 SHALL hold LATCH for 2*HALF cycles with latch=1, pulse=0; each LOW lasts HALF cycles with pulse=0; each HIGH lasts HALF cycles with pulse=1.
REQ-018 SHALL sample all pad_data lanes on the last cycle of LOW k into bit k and invert them; HIGH follows LOW k only for k < N_BITS-1, otherwise DONE.
REQ-019 SHALL make DONE last exactly 1 cycle; poll length = (2 + 2*N_BITS - 1)*HALF + 1 cycles (4081 at defaults).
REQ-020 SHALL register buttons, pressed = new & ~old and valid=1 on the edge leaving DONE; pressed and valid are high for exactly 1 cycle, otherwise 0.
REQ-021 SHALL, in auto mode, start polls every POLL_CYCLES cycles measured from the previous LATCH entry; if POLL_CYCLES <= poll length, the next LATCH follows IDLE after 1 cycle.
REQ-022 SHALL ignore start while busy, and ignore it when auto_mode=1; auto_mode changes take effect only in IDLE.
REQ-023 SHALL keep buttons stable between valid strobes; a pad held pressed yields pressed=0 on later polls.
REQ-024 SHALL drive latch and pulse from registers (glitch-free) and never assert both at once.

Reset
REQ-025 SHALL, with reset=0, on the next clk edge force state IDLE, latch=0, pulse=0, busy=0, buttons=0, pressed=0, valid=0, counters=0, regardless of poll phase; a partial shift is discarded.
REQ-026 SHALL, with auto_mode=1, enter LATCH on the first cycle after reset deasserts.

Structure
REQ-027 SHALL place the FSM state enum and default parameter constants (HALF, POLL_CYCLES) in shared package pad_pkg.
REQ-028 SHALL use one sub-module, pad_shift_reg (N_BITS-wide sample-and-invert shifter), instantiated N_PADS times; timing and the FSM stay in the top module.

Verification (HALF=4, N_BITS=8, N_PADS=2, POLL_CYCLES=200)
REQ-029 SHALL verify a manual poll: auto_mode=0, start pulse, pad0 sends A,Start pressed (bits 0,3 low), pad1 all high -> latch high 8 cycles, 8 LOW/7 HIGH phases, valid 69 cycles after LATCH entry, buttons=16'h0009, pressed=16'h0009.
REQ-030 SHALL verify held buttons: the same pattern polled twice -> second valid shows buttons=16'h0009, pressed=0.
REQ-031 SHALL verify auto mode: auto_mode=1 for 1000 cycles -> LATCH entries exactly 200 cycles apart, 5 valid strobes.
REQ-032 SHALL verify reset mid-shift: reset=0 during HIGH of bit 4 -> next cycle latch=pulse=busy=0, buttons=0, no valid.
REQ-033 SHALL verify start while busy: a second start 10 cycles into a poll -> ignored, exactly one valid, busy low after DONE.
REQ-034 SHALL verify pad independence: pad1 bit 7 low, pad0 all high -> buttons=16'h8000.
